// File: rtl/apb_pkg.sv
// Shared types and encodings for the CPU-to-APB master bridge.
// Imported by the bridge FSM and its lane-alignment helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Low two bits of the load/store func3
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] PERIPH_BASE_DEF = 32'h1000_0000;

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB4 bus bundle between the bridge (master) and up to NUM_SLV peripherals.
// PRDATA is flattened: slave i occupies bits [32i+31:32i].
interface apb_master_bridge_if #(
    parameter int NUM_SLV = 4
);
    logic [31:0]           PADDR;
    logic [NUM_SLV-1:0]    PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PWDATA;
    logic [3:0]            PSTRB;
    logic [32*NUM_SLV-1:0] PRDATA;
    logic [NUM_SLV-1:0]    PREADY;
    logic [NUM_SLV-1:0]    PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_lane_align.sv
// Byte-lane helper: write strobes and replication, read right-alignment with
// zero fill, and misalignment detection for byte/half/word accesses.
module apb_lane_align
    import apb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] prdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [31:0] shifted;

    assign shifted = prdata >> {addr_lo, 3'b000};

    always_comb begin
        strb      = 4'b0000;
        wdata_rep = 32'h0;
        rdata     = 32'h0;
        misalign  = 1'b0;
        case (size)
            SZ_BYTE: begin
                strb      = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata     = {24'h0, shifted[7:0]};
            end
            SZ_HALF: begin
                strb      = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                rdata     = {16'h0, shifted[15:0]};
                misalign  = addr_lo[0];
            end
            SZ_WORD: begin
                strb      = 4'b1111;
                wdata_rep = wdata;
                rdata     = shifted;
                misalign  = |addr_lo;
            end
            // Size 11 has no legal encoding and is rejected like a misalignment
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Turns one CPU load/store into a single APB4 transfer: decode, lane handling,
// slave timeout, and a one-cycle busReady completion pulse.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int          NUM_SLV     = 4,
    parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        busReq,
    input  logic        busWe,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    input  logic [2:0]  busSize,
    output logic [31:0] busRData,
    output logic        busReady,
    output logic        busErr,
    apb_master_bridge_if.master apb
);

    localparam int         IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [7:0] TMO   = 8'(TIMEOUT_CYC);

    state_t             state, state_d;
    logic [7:0]         cnt, cnt_d, cnt_inc;

    // Per-transfer context captured when a request is accepted
    logic               we_q;
    logic [1:0]         size_q;
    logic [1:0]         lo_q;
    logic [IDX_W-1:0]   idx_q;

    logic [IDX_W-1:0]   req_idx;
    logic               region_miss, req_bad;
    logic [1:0]         al_size, al_lo;
    logic [31:0]        prdata_sel;
    logic               pready_sel, pslverr_sel;
    logic [3:0]         al_strb;
    logic [31:0]        al_wdata, al_rdata;
    logic               al_misalign;

    logic [31:0]        paddr_d, pwdata_d, rdata_d;
    logic [NUM_SLV-1:0] psel_d;
    logic               penable_d, pwrite_d, err_d, ready_d;
    logic [3:0]         pstrb_d;

    logic               unused_size2;
    assign unused_size2 = busSize[2];

    assign req_idx     = busAddr[12 +: IDX_W];
    assign region_miss = (busAddr[31:16] != PERIPH_BASE[31:16]) ||
                         (32'(req_idx) >= 32'(NUM_SLV));
    assign req_bad     = region_miss | al_misalign;

    // IDLE aligns the live request; later states align the captured context
    assign al_size     = (state == IDLE) ? busSize[1:0] : size_q;
    assign al_lo       = (state == IDLE) ? busAddr[1:0] : lo_q;
    assign prdata_sel  = apb.PRDATA[{idx_q, 5'b00000} +: 32];
    assign pready_sel  = apb.PREADY[idx_q];
    assign pslverr_sel = apb.PSLVERR[idx_q];
    assign cnt_inc     = cnt + 8'd1;

    apb_lane_align u_align (
        .size      (al_size),
        .addr_lo   (al_lo),
        .wdata     (busWData),
        .prdata    (prdata_sel),
        .strb      (al_strb),
        .wdata_rep (al_wdata),
        .rdata     (al_rdata),
        .misalign  (al_misalign)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            apb.PADDR   <= 32'h0;
            apb.PSEL    <= '0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PWDATA  <= 32'h0;
            apb.PSTRB   <= 4'b0000;
            busRData    <= 32'h0;
            busErr      <= 1'b0;
            busReady    <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            apb.PADDR   <= paddr_d;
            apb.PSEL    <= psel_d;
            apb.PENABLE <= penable_d;
            apb.PWRITE  <= pwrite_d;
            apb.PWDATA  <= pwdata_d;
            apb.PSTRB   <= pstrb_d;
            busRData    <= rdata_d;
            busErr      <= err_d;
            busReady    <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && busReq) begin
            we_q   <= busWe;
            size_q <= busSize[1:0];
            lo_q   <= busAddr[1:0];
            idx_q  <= req_idx;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (busReq) state_d = req_bad ? RESP : SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready_sel || cnt_inc == TMO) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        paddr_d   = apb.PADDR;
        psel_d    = apb.PSEL;
        penable_d = apb.PENABLE;
        pwrite_d  = apb.PWRITE;
        pwdata_d  = apb.PWDATA;
        pstrb_d   = apb.PSTRB;
        rdata_d   = busRData;
        err_d     = busErr;
        ready_d   = 1'b0;
        cnt_d     = 8'd0;
        case (state)
            IDLE: begin
                if (busReq) begin
                    if (req_bad) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        paddr_d   = {busAddr[31:2], 2'b00};
                        psel_d    = NUM_SLV'(1) << req_idx;
                        penable_d = 1'b0;
                        pwrite_d  = busWe;
                        pwdata_d  = al_wdata;
                        pstrb_d   = busWe ? al_strb : 4'b0000;
                    end
                end
            end
            SETUP: penable_d = 1'b1;
            ACCESS: begin
                cnt_d = cnt_inc;
                if (pready_sel) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    rdata_d   = we_q ? 32'h0 : al_rdata;
                    err_d     = pslverr_sel;
                    ready_d   = 1'b1;
                end else if (cnt_inc == TMO) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    rdata_d   = 32'h0;
                    err_d     = 1'b1;
                    ready_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: behavioural APB slaves with configurable wait
// states, errors and hangs; expected responses queued per request.
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        busReq, busWe;
    logic [31:0] busAddr, busWData, busRData;
    logic [2:0]  busSize;
    logic        busReady, busErr;

    always #5 clk = ~clk;

    apb_master_bridge_if #(.NUM_SLV(4)) apb ();

    apb_master_bridge #(
        .NUM_SLV(4), .PERIPH_BASE(32'h1000_0000), .TIMEOUT_CYC(255)
    ) dut (
        .clk(clk), .reset(reset), .busReq(busReq), .busWe(busWe),
        .busAddr(busAddr), .busWData(busWData), .busSize(busSize),
        .busRData(busRData), .busReady(busReady), .busErr(busErr), .apb(apb)
    );

    // Slave models: PREADY after slv_wait ACCESS cycles unless hung
    logic [31:0] slv_data [4];
    int          slv_wait [4];
    logic [3:0]  slv_err, slv_hang, pready_v;
    int          acc_cnt = 0;

    always_comb begin
        for (int i = 0; i < 4; i++)
            pready_v[i] = apb.PENABLE && !slv_hang[i] && (acc_cnt >= slv_wait[i]);
    end
    assign apb.PREADY  = pready_v;
    assign apb.PSLVERR = slv_err;
    assign apb.PRDATA  = {slv_data[3], slv_data[2], slv_data[1], slv_data[0]};

    always @(posedge clk) begin
        if (apb.PENABLE && ((apb.PREADY & apb.PSEL) == 4'b0000)) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    typedef struct { logic [31:0] rdata; logic err; int lat; } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int errors = 0;
    int checks = 0;

    int          obs_lat, obs_pen;
    logic        obs_got, obs_err, obs_ready_after, obs_pwrite, obs_unstable, seen;
    logic [3:0]  obs_psel, obs_pstrb;
    logic [31:0] obs_paddr, obs_pwdata, obs_rdata;
    logic [4:0]  obs_bus_at_ready;
    logic [68:0] snap;

    // Drive one request and watch it until busReady (bounded)
    task automatic run_req(input logic hold, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] size);
        @(posedge clk); #1;
        busReq = 1'b1; busWe = we; busAddr = addr; busWData = wdata; busSize = size;
        obs_lat = 0; obs_pen = 0; obs_got = 1'b0; obs_psel = 4'b0; obs_unstable = 1'b0;
        seen = 1'b0; obs_paddr = 32'h0; obs_pstrb = 4'h0; obs_pwdata = 32'h0; obs_pwrite = 1'b0;
        while (!obs_got && obs_lat < 400) begin
            @(negedge clk);
            if (busReady) begin
                obs_got = 1'b1; obs_rdata = busRData; obs_err = busErr;
                obs_bus_at_ready = {apb.PSEL, apb.PENABLE};
            end else begin
                obs_lat++;
                obs_psel |= apb.PSEL;
                if (apb.PENABLE) obs_pen++;
                if (apb.PSEL != 4'b0) begin
                    if (seen && snap != {apb.PADDR, apb.PSTRB, apb.PWDATA, apb.PWRITE})
                        obs_unstable = 1'b1;
                    snap = {apb.PADDR, apb.PSTRB, apb.PWDATA, apb.PWRITE};
                    seen = 1'b1;
                    obs_paddr = apb.PADDR; obs_pstrb = apb.PSTRB;
                    obs_pwdata = apb.PWDATA; obs_pwrite = apb.PWRITE;
                end
            end
        end
        obs_ready_after = 1'b0;
        if (!hold) begin
            busReq = 1'b0;
            @(negedge clk);
            obs_ready_after = busReady;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; busReq = 1'b0; busWe = 1'b0; busAddr = 32'h0; busWData = 32'h0; busSize = 3'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busReady, busErr, busRData} !== 34'h0)
            $display("FAIL reset_bus: got %h want 0", {busReady, busErr, busRData});
        checks++;
        if ({apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB} !== 74'h0)
            $display("FAIL reset_apb: got %h want 0",
                     {apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB});
        if ({busReady, busErr, busRData} !== 34'h0) errors++;
        if ({apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB} !== 74'h0) errors++;
        @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic test_store_word();
        slv_err[3] = 1'b1;  // unselected slave error must be ignored
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 3});
        run_req(1'b0, 1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 3'b010);
        e = exp_q.pop_front();
        checks++;
        if (obs_got !== 1'b1) begin errors++; $display("FAIL sw_done: got %b want 1", obs_got); end
        checks++;
        if ({obs_rdata, obs_err} !== {e.rdata, e.err}) begin
            errors++; $display("FAIL sw_resp: got %h/%b want %h/%b", obs_rdata, obs_err, e.rdata, e.err);
        end
        checks++;
        if (obs_lat != e.lat) begin errors++; $display("FAIL sw_lat: got %0d want %0d", obs_lat, e.lat); end
        checks++;
        if ({obs_psel, obs_paddr, obs_pstrb, obs_pwdata, obs_pwrite} !==
            {4'b0010, 32'h1000_1004, 4'hF, 32'hDEAD_BEEF, 1'b1}) begin
            errors++;
            $display("FAIL sw_apb: got %h %h %h %h %b want 2 10001004 f deadbeef 1",
                     obs_psel, obs_paddr, obs_pstrb, obs_pwdata, obs_pwrite);
        end
        checks++;
        if (obs_pen != 1 || obs_unstable !== 1'b0) begin
            errors++; $display("FAIL sw_penable: got %0d/%b want 1/0", obs_pen, obs_unstable);
        end
        checks++;
        if ({obs_bus_at_ready, obs_ready_after} !== 6'b0) begin
            errors++; $display("FAIL sw_release: got %b want 000000", {obs_bus_at_ready, obs_ready_after});
        end
        slv_err[3] = 1'b0;
    endtask

    task automatic test_store_sub();
        logic [31:0] addrs [2];
        logic [2:0]  sizes [2];
        logic [31:0] wds [2], exp_pw [2], exp_pa [2];
        logic [3:0]  exp_st [2];
        addrs = '{32'h1000_2003, 32'h1000_2002};
        sizes = '{3'b000, 3'b001};
        wds   = '{32'h1234_56A5, 32'hFFFF_1234};
        exp_pw = '{32'hA5A5_A5A5, 32'h1234_1234};
        exp_pa = '{32'h1000_2000, 32'h1000_2000};
        exp_st = '{4'b1000, 4'b1100};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 3});
            run_req(1'b0, 1'b1, addrs[i], wds[i], sizes[i]);
            e = exp_q.pop_front();
            checks++;
            if ({obs_got, obs_rdata, obs_err} !== {1'b1, e.rdata, e.err} || obs_lat != e.lat) begin
                errors++;
                $display("FAIL sub_resp%0d: got %b/%h/%b lat %0d want 1/%h/%b lat %0d",
                         i, obs_got, obs_rdata, obs_err, obs_lat, e.rdata, e.err, e.lat);
            end
            checks++;
            if ({obs_psel, obs_paddr, obs_pstrb, obs_pwdata} !== {4'b0100, exp_pa[i], exp_st[i], exp_pw[i]}) begin
                errors++;
                $display("FAIL sub_apb%0d: got %h %h %h %h want 4 %h %h %h",
                         i, obs_psel, obs_paddr, obs_pstrb, obs_pwdata, exp_pa[i], exp_st[i], exp_pw[i]);
            end
        end
    endtask

    task automatic test_load();
        logic [31:0] addrs [3], exp_rd [3];
        logic [2:0]  sizes [3];
        slv_data[0] = 32'hBEEF_1234; slv_wait[0] = 2;
        addrs  = '{32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
        sizes  = '{3'b001, 3'b100, 3'b010};
        exp_rd = '{32'h0000_BEEF, 32'h0000_0012, 32'hBEEF_1234};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{rdata: exp_rd[i], err: 1'b0, lat: 5});
            run_req(1'b0, 1'b0, addrs[i], 32'hFFFF_FFFF, sizes[i]);
            e = exp_q.pop_front();
            checks++;
            if ({obs_got, obs_rdata, obs_err} !== {1'b1, e.rdata, e.err}) begin
                errors++;
                $display("FAIL ld_data%0d: got %b/%h/%b want 1/%h/%b", i, obs_got, obs_rdata, obs_err, e.rdata, e.err);
            end
            checks++;
            if (obs_lat != e.lat || obs_pen != 3 || {obs_psel, obs_pstrb, obs_pwrite} !== {4'b0001, 4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL ld_apb%0d: got lat %0d pen %0d sel %h strb %h wr %b want lat 5 pen 3 sel 1 strb 0 wr 0",
                         i, obs_lat, obs_pen, obs_psel, obs_pstrb, obs_pwrite);
            end
        end
        slv_wait[0] = 0;
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        logic [2:0]  sizes [4];
        logic        wes [4];
        addrs = '{32'h1000_0001, 32'h2000_0000, 32'h1000_0000, 32'h1000_0003};
        sizes = '{3'b010, 3'b000, 3'b011, 3'b001};
        wes   = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
            run_req(1'b0, wes[i], addrs[i], 32'h5555_AAAA, sizes[i]);
            e = exp_q.pop_front();
            checks++;
            if ({obs_got, obs_rdata, obs_err, obs_psel} !== {1'b1, e.rdata, e.err, 4'b0000} || obs_lat != e.lat) begin
                errors++;
                $display("FAIL err%0d: got %b/%h/%b sel %h lat %0d want 1/%h/%b sel 0 lat %0d",
                         i, obs_got, obs_rdata, obs_err, obs_psel, obs_lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_timeout_slverr();
        slv_hang[3] = 1'b1;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 257});
        run_req(1'b0, 1'b0, 32'h1000_3000, 32'h0, 3'b010);
        e = exp_q.pop_front();
        checks++;
        if ({obs_got, obs_rdata, obs_err} !== {1'b1, e.rdata, e.err} || obs_lat != e.lat || obs_pen != 255) begin
            errors++;
            $display("FAIL timeout: got %b/%h/%b lat %0d pen %0d want 1/%h/%b lat %0d pen 255",
                     obs_got, obs_rdata, obs_err, obs_lat, obs_pen, e.rdata, e.err, e.lat);
        end
        checks++;
        if ({obs_psel, obs_bus_at_ready} !== {4'b1000, 5'b0}) begin
            errors++; $display("FAIL timeout_bus: got %h/%b want 8/00000", obs_psel, obs_bus_at_ready);
        end
        slv_hang[3] = 1'b0;
        slv_err[2] = 1'b1; slv_data[2] = 32'hCAFE_F00D;
        exp_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b1, lat: 3});
        run_req(1'b0, 1'b0, 32'h1000_2000, 32'h0, 3'b010);
        e = exp_q.pop_front();
        checks++;
        if ({obs_got, obs_rdata, obs_err} !== {1'b1, e.rdata, e.err} || obs_lat != e.lat) begin
            errors++;
            $display("FAIL slverr: got %b/%h/%b lat %0d want 1/%h/%b lat %0d",
                     obs_got, obs_rdata, obs_err, obs_lat, e.rdata, e.err, e.lat);
        end
        slv_err[2] = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   n;
        logic got2;
        logic [3:0] sel2;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 3});
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 3});
        run_req(1'b1, 1'b1, 32'h1000_1000, 32'h0BAD_CAFE, 3'b010);
        e = exp_q.pop_front();
        checks++;
        if ({obs_got, obs_err} !== {1'b1, e.err} || obs_lat != e.lat) begin
            errors++; $display("FAIL b2b_first: got %b/%b lat %0d want 1/0 lat 3", obs_got, obs_err, obs_lat);
        end
        // Request stays high into the following IDLE cycle with new address
        busAddr = 32'h1000_2000; busWData = 32'h1122_3344;
        n = 0; got2 = 1'b0; sel2 = 4'b0;
        while (!got2 && n < 20) begin
            @(negedge clk);
            if (busReady) got2 = 1'b1;
            else begin
                n++;
                sel2 |= apb.PSEL;
                if (apb.PENABLE) obs_pwdata = apb.PWDATA;
            end
        end
        busReq = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({got2, busErr, sel2, obs_pwdata} !== {1'b1, e.err, 4'b0100, 32'h1122_3344} || n != e.lat) begin
            errors++;
            $display("FAIL b2b_second: got %b/%b sel %h pw %h n %0d want 1/0 sel 4 pw 11223344 n %0d",
                     got2, busErr, sel2, obs_pwdata, n, e.lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int rdy_seen;
        slv_hang[3] = 1'b1;
        @(posedge clk); #1;
        busReq = 1'b1; busWe = 1'b0; busAddr = 32'h1000_3000; busSize = 3'b010;
        repeat (4) @(negedge clk);
        checks++;
        if ({apb.PSEL, apb.PENABLE} !== 5'b10001) begin
            errors++; $display("FAIL mid_access: got %b want 10001", {apb.PSEL, apb.PENABLE});
        end
        @(posedge clk); #1; reset = 1'b1; busReq = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({apb.PSEL, apb.PENABLE, busReady} !== 6'b0) begin
            errors++; $display("FAIL mid_reset: got %b want 000000", {apb.PSEL, apb.PENABLE, busReady});
        end
        reset = 1'b0;
        rdy_seen = 0;
        repeat (5) begin @(negedge clk); if (busReady || apb.PSEL != 4'b0) rdy_seen++; end
        checks++;
        if (rdy_seen != 0) begin errors++; $display("FAIL mid_quiet: got %0d want 0", rdy_seen); end
        slv_hang[3] = 1'b0;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 3});
        run_req(1'b0, 1'b1, 32'h1000_3008, 32'h7777_8888, 3'b010);
        e = exp_q.pop_front();
        checks++;
        if ({obs_got, obs_err, obs_psel, obs_pwdata} !== {1'b1, e.err, 4'b1000, 32'h7777_8888} || obs_lat != e.lat) begin
            errors++;
            $display("FAIL mid_after: got %b/%b sel %h pw %h lat %0d want 1/0 sel 8 pw 77778888 lat 3",
                     obs_got, obs_err, obs_psel, obs_pwdata, obs_lat);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin slv_data[i] = 32'h0; slv_wait[i] = 0; end
        slv_err = 4'b0; slv_hang = 4'b0;
        test_reset();
        test_store_word();
        test_store_sub();
        test_load();
        test_errors();
        test_timeout_slverr();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
